sa_cache_way_mem: RTL

SA_CACHE_WAY_MEM -- requirements
Module: sa_cache_way_mem

---
 rtl/sa_cache_way_mem_pkg.sv | 30 +++
 rtl/sa_cache_way_bank.sv | 43 ++++
 rtl/sa_cache_way_mem.sv | 110 +++++++++++
 3 files changed

// File: rtl/sa_cache_way_mem_pkg.sv
// Shared definitions for the set-associative cache way memory: default geometry,
// FSM state encoding and request/response record layouts.
package cache_definition;

   localparam int WAYS_DEF   = 4;
   localparam int SETS_DEF   = 256;
   localparam int LINE_W_DEF = 128;
   localparam int IDX_W_DEF  = $clog2(SETS_DEF);
   localparam int WAY_W_DEF  = $clog2(WAYS_DEF);
   localparam int WORDS_DEF  = LINE_W_DEF / 32;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   typedef struct packed {
      logic                   we;
      logic [IDX_W_DEF-1:0]   index;
      logic [WAY_W_DEF-1:0]   way;
      logic [WORDS_DEF-1:0]   word_en;
      logic [LINE_W_DEF-1:0]  wdata;
   } cache_req_t;

   typedef struct packed {
      logic                           valid;
      logic [WAYS_DEF*LINE_W_DEF-1:0] rdata;
   } cache_rsp_t;

endpackage

// File: rtl/sa_cache_way_bank.sv
// One way of the cache: single-port SETS x LINE_W RAM with 32-bit word enables
// and a registered read port that holds its value between reads.
module sa_cache_way_bank #(
   parameter int SETS   = 256,
   parameter int LINE_W = 128,
   localparam int IDX_W = $clog2(SETS),
   localparam int WORDS = LINE_W / 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [WORDS-1:0]  wen_i,
   input  logic [LINE_W-1:0] wdata_i,
   output logic [LINE_W-1:0] rdata_o
);

   logic [LINE_W-1:0] mem_q [SETS];
   logic [LINE_W-1:0] rdata_q;

   // Array contents are never reset; the owner clears them with a sweep.
   always_ff @(posedge clk) begin
      if (en_i && we_i) begin
         for (int w = 0; w < WORDS; w++) begin
            if (wen_i[w]) begin
               mem_q[addr_i][w*32 +: 32] <= wdata_i[w*32 +: 32];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (en_i && !we_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sa_cache_way_mem.sv
// Set-associative way memory: WAYS banks sharing one index, a clear-sweep FSM
// after reset or flush, per-way writes and whole-set reads with latency 1.
module sa_cache_way_mem
   import cache_definition::*;
#(
   parameter int WAYS   = WAYS_DEF,
   parameter int SETS   = SETS_DEF,
   parameter int LINE_W = LINE_W_DEF,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
   localparam int WORDS = LINE_W / 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   input  logic                   req_we,
   input  logic [IDX_W-1:0]       req_index,
   input  logic [WAY_W-1:0]       req_way,
   input  logic [WORDS-1:0]       req_word_en,
   input  logic [LINE_W-1:0]      req_wdata,
   output logic                   req_ready,
   input  logic                   flush,
   output logic                   init_busy,
   output logic                   rsp_valid,
   output logic [WAYS*LINE_W-1:0] rsp_rdata
);

   state_e           state_q;
   logic [IDX_W-1:0] cnt_q;
   logic             rsp_valid_q;

   logic             accept;
   logic             rd_accept;
   logic [IDX_W-1:0] bank_addr;
   logic [WORDS-1:0] bank_wen;
   logic [LINE_W-1:0] bank_wdata;
   logic [WAYS-1:0]  bank_en;
   logic [WAYS-1:0]  bank_we;

   assign init_busy = (state_q == ST_INIT);
   assign req_ready = (state_q == ST_READY) && !flush;
   assign accept    = req_valid && req_ready;
   assign rd_accept = accept && !req_we;
   assign rsp_valid = rsp_valid_q;

   // During the sweep the counter owns the shared address/data lines.
   always_comb begin
      bank_addr  = req_index;
      bank_wen   = req_word_en;
      bank_wdata = req_wdata;
      if (init_busy) begin
         bank_addr  = cnt_q;
         bank_wen   = '1;
         bank_wdata = '0;
      end
   end

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      assign bank_en[g] = init_busy || (accept && (!req_we || (req_way == WAY_W'(g))));
      assign bank_we[g] = init_busy || req_we;

      sa_cache_way_bank #(
         .SETS   (SETS),
         .LINE_W (LINE_W)
      ) u_bank (
         .clk     (clk),
         .rst_n   (rst_n),
         .en_i    (bank_en[g]),
         .we_i    (bank_we[g]),
         .addr_i  (bank_addr),
         .wen_i   (bank_wen),
         .wdata_i (bank_wdata),
         .rdata_o (rsp_rdata[g*LINE_W +: LINE_W])
      );
   end

   // A flush, in either state, restarts the sweep from set 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         rsp_valid_q <= rd_accept;
         if (flush) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_INIT: begin
                  if (cnt_q == IDX_W'(SETS - 1)) begin
                     state_q <= ST_READY;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + IDX_W'(1);
                  end
               end
               ST_READY: begin
                  state_q <= ST_READY;
               end
               default: begin
                  state_q <= ST_INIT;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

endmodule
